// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB pipeline register: asynchronous-read data RAM,
// sub-word loads/stores with extension, stall/flush control and a sticky misalignment flag.
module mem_stage #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        LoadSigned,
  input  logic [31:0] RegOut2,
  input  logic [31:0] AluOut,
  input  logic [4:0]  Addr,
  input  logic        Stall,
  input  logic        Flush,
  output logic        MemtoReg_,
  output logic        RegWrite_,
  output logic [31:0] RdData_,
  output logic [31:0] AluOut_,
  output logic [4:0]  Addr_,
  output logic [31:0] WbData,
  output logic        AddrErr
);

  logic [31:0]          r_mem [2**ADDR_BITS];
  logic                 r_memtoreg;
  logic                 r_regwrite;
  logic [31:0]          r_rddata;
  logic [31:0]          r_aluout;
  logic [4:0]           r_addr;
  logic                 r_addrerr;

  logic [ADDR_BITS-1:0] w_idx;
  logic [31:0]          w_word;
  logic                 w_mis;
  logic                 w_we;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_load;
  logic                 w_unused_hi;

  // Address bits above the word index are deliberately ignored so accesses wrap.
  assign w_idx       = AluOut[ADDR_BITS+1:2];
  assign w_unused_hi = ^AluOut[31:ADDR_BITS+2];
  assign w_word      = r_mem[w_idx];

  always_comb begin
    case (MemSize)
      2'b01:   w_mis = AluOut[0];
      2'b10:   w_mis = 1'b0;
      default: w_mis = |AluOut[1:0];
    endcase
  end

  assign w_we = MemWrite & ~Stall & ~Flush & ~w_mis;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign w_be[gi] = (MemSize == 2'b10) ? (AluOut[1:0] == LANE) :
                        (MemSize == 2'b01) ? (AluOut[1] == LANE[1]) : 1'b1;
      assign w_wdata[8*gi +: 8] = (MemSize == 2'b10) ? RegOut2[7:0] :
                                  (MemSize == 2'b01) ? RegOut2[8*(gi%2) +: 8] :
                                                       RegOut2[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    case (AluOut[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = AluOut[1] ? w_word[31:16] : w_word[15:0];
    case (MemSize)
      2'b10:   w_load = {{24{LoadSigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{LoadSigned & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // RAM lives in the reset process only so a store coinciding with rst is dropped; it is never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_rddata   <= 32'd0;
      r_aluout   <= 32'd0;
      r_addr     <= 5'd0;
      r_addrerr  <= 1'b0;
    end else begin
      if (w_we) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
      if (!Stall) begin
        r_memtoreg <= MemtoReg & ~Flush;
        r_regwrite <= RegWrite & ~(MemtoReg & w_mis) & ~Flush;
        r_rddata   <= MemtoReg ? w_load : 32'd0;
        r_aluout   <= AluOut;
        r_addr     <= Addr;
        if (!Flush && (MemtoReg || MemWrite) && w_mis) r_addrerr <= 1'b1;
      end
    end
  end

  assign MemtoReg_ = r_memtoreg;
  assign RegWrite_ = r_regwrite;
  assign RdData_   = r_rddata;
  assign AluOut_   = r_aluout;
  assign Addr_     = r_addr;
  assign AddrErr   = r_addrerr;
  assign WbData    = r_memtoreg ? r_rddata : r_aluout;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset sequence, then random traffic
// checked against a byte-addressed memory model.
module tb_mem_stage;
  localparam int AB = 10;
  localparam int NB = 4 << AB;

  logic        clk = 1'b0, rst = 1'b1;
  logic        MemtoReg = 1'b0, RegWrite = 1'b0, MemWrite = 1'b0, LoadSigned = 1'b0;
  logic        Stall = 1'b0, Flush = 1'b0;
  logic [1:0]  MemSize = 2'b00;
  logic [31:0] RegOut2 = 32'd0, AluOut = 32'd0;
  logic [4:0]  Addr = 5'd0;
  logic        MemtoReg_, RegWrite_, AddrErr;
  logic [31:0] RdData_, AluOut_, WbData;
  logic [4:0]  Addr_;

  mem_stage #(.ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemSize(MemSize), .LoadSigned(LoadSigned), .RegOut2(RegOut2), .AluOut(AluOut),
    .Addr(Addr), .Stall(Stall), .Flush(Flush), .MemtoReg_(MemtoReg_), .RegWrite_(RegWrite_),
    .RdData_(RdData_), .AluOut_(AluOut_), .Addr_(Addr_), .WbData(WbData), .AddrErr(AddrErr)
  );

  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0;

  // Reference model: byte-addressed memory plus expected MEM/WB contents.
  logic [7:0]  mb [NB];
  logic        e_mtr = 1'b0, e_rw = 1'b0, e_err = 1'b0;
  logic [31:0] e_rd = 32'd0, e_alu = 32'd0;
  logic [4:0]  e_addr = 5'd0;

  typedef struct {
    logic        mw, mtr, rw;
    logic [1:0]  sz;
    logic        sg, st, fl;
    logic [31:0] wd, alu;
    logic [4:0]  ad;
    logic [31:0] x_rd, x_wb;
    logic        x_rw, x_err;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic mw, mtr, rw, input logic [1:0] sz, input logic sg, st, fl,
                              input logic [31:0] wd, alu, input logic [4:0] ad,
                              input logic [31:0] x_rd, x_wb, input logic x_rw, x_err);
    vec_t v;
    v.mw = mw; v.mtr = mtr; v.rw = rw; v.sz = sz; v.sg = sg; v.st = st; v.fl = fl;
    v.wd = wd; v.alu = alu; v.ad = ad; v.x_rd = x_rd; v.x_wb = x_wb; v.x_rw = x_rw; v.x_err = x_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mw, mtr, rw, input logic [1:0] sz, input logic sg, st, fl,
                       input logic [31:0] wd, alu, input logic [4:0] ad);
    MemWrite = mw; MemtoReg = mtr; RegWrite = rw; MemSize = sz; LoadSigned = sg;
    Stall = st; Flush = fl; RegOut2 = wd; AluOut = alu; Addr = ad;
  endtask

  task automatic model_edge();
    int a, n, base;
    logic [31:0] v;
    logic mis;
    if (rst) begin
      e_mtr = 0; e_rw = 0; e_err = 0; e_rd = 0; e_alu = 0; e_addr = 0;
      return;
    end
    a    = int'(AluOut % 32'(NB));
    n    = (MemSize == 2'b10) ? 1 : (MemSize == 2'b01) ? 2 : 4;
    mis  = (a % n) != 0;
    base = a - (a % n);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[base + k]) << (8 * k));
    if (LoadSigned && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    if (MemWrite && !Stall && !Flush && !mis)
      for (int k = 0; k < n; k++) mb[base + k] = RegOut2[8*k +: 8];
    if (!Stall) begin
      e_mtr  = MemtoReg & ~Flush;
      e_rw   = RegWrite & ~(MemtoReg & mis) & ~Flush;
      e_rd   = MemtoReg ? v : 32'd0;
      e_alu  = AluOut;
      e_addr = Addr;
      if (!Flush && (MemtoReg || MemWrite) && mis) e_err = 1'b1;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_MemtoReg_"}, 32'(MemtoReg_), 32'(e_mtr));
    chk({tag, "_RegWrite_"}, 32'(RegWrite_), 32'(e_rw));
    chk({tag, "_RdData_"},   RdData_, e_rd);
    chk({tag, "_AluOut_"},   AluOut_, e_alu);
    chk({tag, "_Addr_"},     32'(Addr_), 32'(e_addr));
    chk({tag, "_WbData"},    WbData, e_mtr ? e_rd : e_alu);
    chk({tag, "_AddrErr"},   32'(AddrErr), 32'(e_err));
  endtask

  initial begin
    tbl[0]  = mk(1,0,0,2'b00,0,0,0,32'hDEADBEEF,32'h40,  0, 32'h0,        32'h40,       0,0);
    tbl[1]  = mk(0,1,1,2'b00,0,0,0,32'h0,       32'h40,  5, 32'hDEADBEEF, 32'hDEADBEEF, 1,0);
    tbl[2]  = mk(1,0,0,2'b00,0,0,0,32'hCAFEF00D,32'h1040,0, 32'h0,        32'h1040,     0,0);
    tbl[3]  = mk(0,1,1,2'b00,0,0,0,32'h0,       32'h40,  6, 32'hCAFEF00D, 32'hCAFEF00D, 1,0);
    tbl[4]  = mk(1,0,0,2'b00,0,0,0,32'hDEADBEEF,32'h1040,0, 32'h0,        32'h1040,     0,0);
    tbl[5]  = mk(1,0,0,2'b10,0,0,0,32'hAAAAAA12,32'h41,  0, 32'h0,        32'h41,       0,0);
    tbl[6]  = mk(0,1,1,2'b00,0,0,0,32'h0,       32'h40,  7, 32'hDEAD12EF, 32'hDEAD12EF, 1,0);
    tbl[7]  = mk(0,1,1,2'b10,1,0,0,32'h0,       32'h43,  8, 32'hFFFFFFDE, 32'hFFFFFFDE, 1,0);
    tbl[8]  = mk(0,1,1,2'b10,0,0,0,32'h0,       32'h43,  9, 32'h000000DE, 32'h000000DE, 1,0);
    tbl[9]  = mk(0,1,1,2'b01,1,0,0,32'h0,       32'h42, 10, 32'hFFFFDEAD, 32'hFFFFDEAD, 1,0);
    tbl[10] = mk(0,1,1,2'b01,0,0,0,32'h0,       32'h40, 11, 32'h000012EF, 32'h000012EF, 1,0);
    tbl[11] = mk(1,0,0,2'b01,0,0,0,32'h00005555,32'h45,  0, 32'h0,        32'h45,       0,1);
    tbl[12] = mk(0,1,1,2'b00,0,0,0,32'h0,       32'h44, 12, 32'hA5A50011, 32'hA5A50011, 1,1);
    tbl[13] = mk(0,1,1,2'b00,0,0,0,32'h0,       32'h42, 13, 32'hDEAD12EF, 32'hDEAD12EF, 0,1);
    tbl[14] = mk(1,0,0,2'b00,0,1,0,32'h0,       32'h40,  0, 32'hDEAD12EF, 32'hDEAD12EF, 0,1);
    tbl[15] = mk(0,1,1,2'b00,0,0,0,32'h0,       32'h40, 14, 32'hDEAD12EF, 32'hDEAD12EF, 1,1);
    tbl[16] = mk(0,1,1,2'b00,0,0,1,32'h0,       32'h40, 15, 32'hDEAD12EF, 32'h40,       0,1);
    tbl[17] = mk(1,0,0,2'b00,0,1,1,32'h0,       32'h40,  0, 32'hDEAD12EF, 32'h40,       0,1);
    tbl[18] = mk(0,0,1,2'b00,0,0,0,32'h0,       32'h12345678,16,32'h0,    32'h12345678, 1,1);
    tbl[19] = mk(0,1,1,2'b00,0,0,0,32'h0,       32'h40, 17, 32'hDEAD12EF, 32'hDEAD12EF, 1,1);

    // Reset state
    #12;
    chk("rst_MemtoReg_", 32'(MemtoReg_), 32'd0);
    chk("rst_RegWrite_", 32'(RegWrite_), 32'd0);
    chk("rst_RdData_",   RdData_, 32'd0);
    chk("rst_AluOut_",   AluOut_, 32'd0);
    chk("rst_Addr_",     32'(Addr_), 32'd0);
    chk("rst_WbData",    WbData, 32'd0);
    chk("rst_AddrErr",   32'(AddrErr), 32'd0);
    rst = 1'b0;

    // Give every RAM word a known value.
    for (int i = 0; i < (1 << AB); i++) begin
      drive(1,0,0,2'b00,0,0,0, 32'(i) ^ 32'hA5A50000, 32'(i * 4), 5'd0);
      cycle();
    end

    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].mw, tbl[r].mtr, tbl[r].rw, tbl[r].sz, tbl[r].sg, tbl[r].st, tbl[r].fl,
            tbl[r].wd, tbl[r].alu, tbl[r].ad);
      cycle();
      chk($sformatf("vec%0d_RdData_", r),   RdData_, tbl[r].x_rd);
      chk($sformatf("vec%0d_WbData", r),    WbData, tbl[r].x_wb);
      chk($sformatf("vec%0d_RegWrite_", r), 32'(RegWrite_), 32'(tbl[r].x_rw));
      chk($sformatf("vec%0d_AddrErr", r),   32'(AddrErr), 32'(tbl[r].x_err));
      check_model($sformatf("vec%0d", r));
    end

    // Asynchronous reset mid-cycle clears at once; a store on a reset edge is dropped.
    #2 rst = 1'b1;
    #1;
    chk("midrst_RdData_",   RdData_, 32'd0);
    chk("midrst_WbData",    WbData, 32'd0);
    chk("midrst_RegWrite_", 32'(RegWrite_), 32'd0);
    chk("midrst_AddrErr",   32'(AddrErr), 32'd0);
    chk("midrst_Addr_",     32'(Addr_), 32'd0);
    drive(1,0,0,2'b00,0,0,0,32'h77777777,32'h40,5'd0);
    cycle();
    check_model("rsthold");
    rst = 1'b0;
    drive(0,1,1,2'b00,0,0,0,32'h0,32'h40,5'd9);
    cycle();
    chk("postrst_RdData_", RdData_, 32'hDEAD12EF);
    chk("postrst_Addr_",   32'(Addr_), 32'd9);
    check_model("postrst");

    // Random traffic against the model.
    for (int t = 0; t < 500; t++) begin
      int op;
      logic [31:0] alu;
      op  = int'($urandom_range(0, 2));
      alu = $urandom;
      alu[11:2] = 10'($urandom_range(16, 31));
      drive(op == 0, op == 1, 1'($urandom), 2'($urandom), 1'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom, alu, 5'($urandom));
      cycle();
      check_model($sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
